dspm_init_engine: RTL

DSPM_INIT_ENGINE -- requirements
Module: dspm_init_engine

---
 rtl/std_cache_pkg.sv | 65 ++++++
 rtl/dspm_init_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/std_cache_pkg.sv
// Shared cache/SPM types: request/response ports, the init engine's
// command opcode and status record, and the BADCABLE filler word that the
// SPM controller returns for ways that are not configured as scratchpad.
package std_cache_pkg;

   // Geometry of the data-cache request port.
   localparam int unsigned DCACHE_INDEX_WIDTH = 12;
   localparam int unsigned DCACHE_TAG_WIDTH   = 20;

   // Word counters in the status record cover every 64-bit word of a way.
   localparam int unsigned DSPM_CNT_WIDTH = DCACHE_INDEX_WIDTH - 2;

   // Read data returned by the SPM controller for an inactive way.
   localparam logic [63:0] DSPM_BADCABLE = 64'hCA11_AB1E_BADC_AB1E;

   // Full-word request encoding: 8 bytes, all lanes enabled.
   localparam logic [7:0] DSPM_BE_ALL    = 8'hFF;
   localparam logic [1:0] DSPM_SIZE_WORD = 2'b11;

   typedef enum logic {
      OP_FILL  = 1'b0,   // write pattern into the way
      OP_CHECK = 1'b1    // read back and compare against pattern
   } dspm_op_e;

   typedef enum logic [1:0] {
      DSPM_IDLE = 2'd0,
      DSPM_REQ  = 2'd1,
      DSPM_DONE = 2'd2
   } dspm_state_e;

   // Requester -> SPM controller.
   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [63:0]                   data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [7:0]                    data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   // SPM controller -> requester.
   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;

   // Result of one command, held from done until the next command is taken.
   typedef struct packed {
      logic                      aborted;
      logic                      timeout;
      logic [DSPM_CNT_WIDTH-1:0] mismatch_cnt;
      logic [DSPM_CNT_WIDTH-1:0] first_mismatch_idx;
   } dspm_status_t;

   // Data word that follows `data` in a sequence (64-bit wrapping).
   function automatic logic [63:0] dspm_next_data(input logic [63:0] data,
                                                  input logic        incr);
      return data + {63'd0, incr};
   endfunction

endpackage

// File: rtl/dspm_init_engine.sv
// Scratchpad initialisation engine. Takes one command at a time and walks
// len consecutive 64-bit words of one SPM way, either writing a (possibly
// incrementing) pattern or reading each word back and counting mismatches.
// One request is outstanding at a time; each word is bounded by a wait
// timeout and the walk can be aborted after the word in flight.
module dspm_init_engine
   import std_cache_pkg::*;
#(
   parameter int unsigned  NR_WAYS        = 4,
   parameter int unsigned  IDX_WIDTH      = 12,
   parameter int unsigned  TIMEOUT_CYCLES = 64,
   localparam int unsigned WAY_WIDTH      = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1,
   localparam int unsigned LEN_WIDTH      = IDX_WIDTH - 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   // command
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  dspm_op_e             cmd_op_i,
   input  logic [WAY_WIDTH-1:0] cmd_way_i,
   input  logic [IDX_WIDTH-1:0] cmd_index_i,
   input  logic [LEN_WIDTH-1:0] cmd_len_i,
   input  logic [63:0]          cmd_pattern_i,
   input  logic                 cmd_incr_i,
   input  logic                 abort_i,
   // SPM port
   output dcache_req_i_t        spm_req_o,
   input  dcache_req_o_t        spm_rsp_i,
   // completion
   output logic                 done_o,
   output dspm_status_t         status_o
);

   localparam int unsigned WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   dspm_state_e            state_q;
   dspm_op_e               op_q;
   logic [WAY_WIDTH-1:0]   way_q;
   logic [IDX_WIDTH-1:0]   addr_q;      // address of the word in flight
   logic [63:0]            data_q;      // write / compare value of that word
   logic                   incr_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   word_cnt_q;  // offset of the word in flight
   logic [WAIT_WIDTH-1:0]  wait_cnt_q;  // cycles spent waiting on it
   logic                   abort_q;
   dspm_status_t           status_q;

   logic complete;
   logic last_word;
   logic abort_pending;
   logic wait_expired;
   logic rd_mismatch;

   // Writes finish on grant, reads on rvalid; the other response bit is noise.
   assign complete = (state_q == DSPM_REQ) &&
                     ((op_q == OP_FILL) ? spm_rsp_i.data_gnt : spm_rsp_i.data_rvalid);

   assign last_word     = ((word_cnt_q + LEN_WIDTH'(1)) == len_q);
   assign abort_pending = abort_q | abort_i;
   assign wait_expired  = (wait_cnt_q == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));

   // Plain inequality is enough for BADCABLE: the filler is a mismatch
   // unless the expected pattern happens to be that very value.
   assign rd_mismatch = (op_q == OP_CHECK) && (spm_rsp_i.data_rdata != data_q);

   // Command sequencer: accept, walk the words, report.
   // NOTE: every register here is updated with <= so all of them see the
   // pre-edge values of each other, whatever order the statements are in.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= DSPM_IDLE;
         op_q       <= OP_FILL;
         way_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         incr_q     <= 1'b0;
         len_q      <= '0;
         word_cnt_q <= '0;
         wait_cnt_q <= '0;
         abort_q    <= 1'b0;
         status_q   <= '0;
      end else begin
         case (state_q)
            DSPM_IDLE: begin
               if (cmd_valid_i) begin
                  op_q       <= cmd_op_i;
                  way_q      <= cmd_way_i;
                  addr_q     <= cmd_index_i & ~IDX_WIDTH'(7);
                  data_q     <= cmd_pattern_i;
                  incr_q     <= cmd_incr_i;
                  len_q      <= cmd_len_i;
                  word_cnt_q <= '0;
                  wait_cnt_q <= '0;
                  abort_q    <= 1'b0;
                  status_q   <= '0;
                  state_q    <= (cmd_len_i == '0) ? DSPM_DONE : DSPM_REQ;
               end
            end

            DSPM_REQ: begin
               abort_q <= abort_pending;
               if (complete) begin
                  wait_cnt_q <= '0;
                  word_cnt_q <= word_cnt_q + LEN_WIDTH'(1);
                  addr_q     <= addr_q + IDX_WIDTH'(8);
                  data_q     <= dspm_next_data(data_q, incr_q);
                  if (rd_mismatch) begin
                     status_q.mismatch_cnt <= status_q.mismatch_cnt + DSPM_CNT_WIDTH'(1);
                     if (status_q.mismatch_cnt == '0) begin
                        status_q.first_mismatch_idx <= DSPM_CNT_WIDTH'(word_cnt_q);
                     end
                  end
                  // Finishing the last word wins over a pending abort.
                  if (last_word) begin
                     state_q <= DSPM_DONE;
                  end else if (abort_pending) begin
                     status_q.aborted <= 1'b1;
                     state_q          <= DSPM_DONE;
                  end
               end else if (wait_expired) begin
                  status_q.timeout <= 1'b1;
                  state_q          <= DSPM_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_WIDTH'(1);
               end
            end

            DSPM_DONE: begin
               state_q <= DSPM_IDLE;
            end

            default: begin
               state_q <= DSPM_IDLE;
            end
         endcase
      end
   end

   // Request port is a pure decode of registered state, so it falls with
   // the asynchronous reset and never glitches between words.
   always_comb begin
      spm_req_o               = '0;
      spm_req_o.address_index = DCACHE_INDEX_WIDTH'(addr_q);
      spm_req_o.address_tag   = DCACHE_TAG_WIDTH'(way_q);
      spm_req_o.data_wdata    = data_q;
      spm_req_o.data_req      = (state_q == DSPM_REQ);
      spm_req_o.data_we       = (op_q == OP_FILL);
      spm_req_o.data_be       = DSPM_BE_ALL;
      spm_req_o.data_size     = DSPM_SIZE_WORD;
      spm_req_o.kill_req      = 1'b0;
      spm_req_o.tag_valid     = 1'b0;
   end

   assign cmd_ready_o = (state_q == DSPM_IDLE);
   assign done_o      = (state_q == DSPM_DONE);
   assign status_o    = status_q;

endmodule
